// File: rtl/ctrl_monitor.sv
// ctrl_monitor: watches sampled multicycle-controller outputs, tracks the
// expected control-state sequence, counts completed instructions by class
// and flags enable conflicts, branch/flag disagreement and sequence errors.
module ctrl_monitor #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pcen,
   input  logic              memwrite,
   input  logic              irwrite,
   input  logic              regwrite,
   input  logic              alusrca,
   input  logic              iord,
   input  logic              memtoreg,
   input  logic              regdst,
   input  logic              zero,
   input  logic [1:0]        alusrcb,
   input  logic [1:0]        pcsrc,
   input  logic [2:0]        alucontrol,
   input  logic              err_clr,
   input  logic [2:0]        cnt_sel,
   output logic [DATA_W-1:0] cnt_out,
   output logic [2:0]        mstate,
   output logic              instr_done,
   output logic [2:0]        instr_class,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {
      EXP_FETCH   = 3'd0,
      EXP_DECODE  = 3'd1,
      EXP_EXEC    = 3'd2,
      EXP_POSTADR = 3'd3,
      EXP_MEMWB   = 3'd4,
      EXP_RWB     = 3'd5
   } state_t;

   localparam logic [2:0] CL_NONE  = 3'd0;
   localparam logic [2:0] CL_LW    = 3'd1;
   localparam logic [2:0] CL_SW    = 3'd2;
   localparam logic [2:0] CL_RTYPE = 3'd3;
   localparam logic [2:0] CL_BEQ   = 3'd4;
   localparam logic [2:0] CL_ADDI  = 3'd5;
   localparam logic [2:0] CL_J     = 3'd6;

   state_t              state_p1, state_nxt;
   logic                done_p1, done_nxt;
   logic [2:0]          class_p1, class_nxt;
   logic                err_p1, err_nxt;
   logic [1:0]          code_p1, code_nxt;
   logic                bt_nxt;
   logic                match;
   logic [DATA_W-1:0]   cnt_tot_p1, cnt_lw_p1, cnt_sw_p1, cnt_rt_p1;
   logic [DATA_W-1:0]   cnt_beq_p1, cnt_addi_p1, cnt_j_p1, cnt_bt_p1;

   // Signature decode of the current sample
   logic noen, sig_fetch, sig_decode, sig_adr, sig_rex, sig_bex, sig_jex;
   logic sig_mrd, sig_mwr, sig_mwb, sig_awb, sig_rwb, conflict;

   assign noen       = ~pcen & ~irwrite & ~memwrite & ~regwrite;
   assign sig_fetch  = irwrite & pcen & ~iord & ~alusrca & (alusrcb == 2'b01) &
                       (pcsrc == 2'b00) & ~memwrite & ~regwrite & (alucontrol == 3'b010);
   assign sig_decode = noen & ~alusrca & (alusrcb == 2'b11) & (alucontrol == 3'b010);
   assign sig_adr    = noen & alusrca & (alusrcb == 2'b10) & (alucontrol == 3'b010);
   assign sig_rex    = noen & alusrca & (alusrcb == 2'b00) & (pcsrc == 2'b00);
   assign sig_bex    = ~irwrite & ~memwrite & ~regwrite & alusrca & (alusrcb == 2'b00) &
                       (pcsrc == 2'b01) & (alucontrol == 3'b110);
   assign sig_jex    = pcen & ~irwrite & ~memwrite & ~regwrite & (pcsrc == 2'b10);
   assign sig_mrd    = noen & iord;
   assign sig_mwr    = memwrite & iord & ~pcen & ~irwrite & ~regwrite;
   assign sig_mwb    = regwrite & ~regdst & memtoreg;
   assign sig_awb    = regwrite & ~regdst & ~memtoreg;
   assign sig_rwb    = regwrite & regdst & ~memtoreg;
   assign conflict   = (memwrite & regwrite) | (irwrite & ~pcen);

   // Next expectation state, completion report and error classification
   always_comb begin
      state_nxt = EXP_FETCH;
      done_nxt  = 1'b0;
      class_nxt = CL_NONE;
      bt_nxt    = 1'b0;
      match     = 1'b0;
      err_nxt   = 1'b0;
      code_nxt  = 2'b00;
      case (state_p1)
         EXP_FETCH:   if (sig_fetch) begin match = 1'b1; state_nxt = EXP_DECODE; end
         EXP_DECODE:  if (sig_decode) begin match = 1'b1; state_nxt = EXP_EXEC; end
         EXP_EXEC: begin
            if (sig_adr) begin match = 1'b1; state_nxt = EXP_POSTADR; end
            else if (sig_rex) begin match = 1'b1; state_nxt = EXP_RWB; end
            else if (sig_bex) begin
               match = 1'b1; done_nxt = 1'b1; class_nxt = CL_BEQ; bt_nxt = pcen;
            end
            else if (sig_jex) begin match = 1'b1; done_nxt = 1'b1; class_nxt = CL_J; end
         end
         EXP_POSTADR: begin
            // ADR may have been MEMADR or ADDIEX; this sample decides which
            if (sig_mrd) begin match = 1'b1; state_nxt = EXP_MEMWB; end
            else if (sig_mwr) begin match = 1'b1; done_nxt = 1'b1; class_nxt = CL_SW; end
            else if (sig_awb) begin match = 1'b1; done_nxt = 1'b1; class_nxt = CL_ADDI; end
         end
         EXP_MEMWB:   if (sig_mwb) begin match = 1'b1; done_nxt = 1'b1; class_nxt = CL_LW; end
         EXP_RWB:     if (sig_rwb) begin match = 1'b1; done_nxt = 1'b1; class_nxt = CL_RTYPE; end
         default:     match = 1'b0;
      endcase
      if (conflict) begin
         err_nxt = 1'b1; code_nxt = 2'b10;
      end else if (sig_bex && (pcen != zero)) begin
         err_nxt = 1'b1; code_nxt = 2'b11;
      end else if (!match) begin
         err_nxt = 1'b1; code_nxt = 2'b01;
      end
      // An erroneous sample counts nothing and restarts the expectation
      if (err_nxt) begin
         state_nxt = EXP_FETCH;
         done_nxt  = 1'b0;
         class_nxt = CL_NONE;
         bt_nxt    = 1'b0;
      end
   end

   // Expectation state, completion pulse and sticky first-error latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_p1 <= EXP_FETCH;
         done_p1  <= 1'b0;
         class_p1 <= CL_NONE;
         err_p1   <= 1'b0;
         code_p1  <= 2'b00;
      end else begin
         state_p1 <= state_nxt;
         done_p1  <= done_nxt;
         class_p1 <= class_nxt;
         if (err_nxt) begin
            err_p1 <= 1'b1;
            if (!err_p1 || err_clr) code_p1 <= code_nxt;
         end else if (err_clr) begin
            err_p1  <= 1'b0;
            code_p1 <= 2'b00;
         end
      end
   end

   // Instruction counters; all wrap silently at full scale
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_tot_p1  <= '0;
         cnt_lw_p1   <= '0;
         cnt_sw_p1   <= '0;
         cnt_rt_p1   <= '0;
         cnt_beq_p1  <= '0;
         cnt_addi_p1 <= '0;
         cnt_j_p1    <= '0;
         cnt_bt_p1   <= '0;
      end else begin
         if (done_nxt) cnt_tot_p1 <= cnt_tot_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_LW)    cnt_lw_p1   <= cnt_lw_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_SW)    cnt_sw_p1   <= cnt_sw_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_RTYPE) cnt_rt_p1   <= cnt_rt_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_BEQ)   cnt_beq_p1  <= cnt_beq_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_ADDI)  cnt_addi_p1 <= cnt_addi_p1 + 1'b1;
         if (done_nxt && class_nxt == CL_J)     cnt_j_p1    <= cnt_j_p1 + 1'b1;
         if (bt_nxt) cnt_bt_p1 <= cnt_bt_p1 + 1'b1;
      end
   end

   // Counter readback mux
   always_comb begin
      cnt_out = cnt_tot_p1;
      case (cnt_sel)
         3'd1:    cnt_out = cnt_lw_p1;
         3'd2:    cnt_out = cnt_sw_p1;
         3'd3:    cnt_out = cnt_rt_p1;
         3'd4:    cnt_out = cnt_beq_p1;
         3'd5:    cnt_out = cnt_addi_p1;
         3'd6:    cnt_out = cnt_j_p1;
         3'd7:    cnt_out = cnt_bt_p1;
         default: cnt_out = cnt_tot_p1;
      endcase
   end

   assign mstate      = state_p1;
   assign instr_done  = done_p1;
   assign instr_class = class_p1;
   assign err         = err_p1;
   assign err_code    = code_p1;

endmodule

// File: tb/tb_ctrl_monitor.sv
// tb_ctrl_monitor: directed controller-sample sequences; completions are
// queued as expected classes and checked by a monitor on instr_done.
`timescale 1ns/1ps
module tb_ctrl_monitor;

   localparam int K_BASE = 0, K_FETCH = 1, K_DECODE = 2, K_ADR = 3, K_REX = 4, K_BEX = 5;
   localparam int K_JEX = 6, K_MRD = 7, K_MWR = 8, K_MWB = 9, K_AWB = 10, K_RWB = 11, K_CONF = 12;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zero;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  alucontrol;
   logic        err_clr;
   logic [2:0]  cnt_sel;
   logic [15:0] cnt_out;
   logic [2:0]  mstate;
   logic        instr_done;
   logic [2:0]  instr_class;
   logic        err;
   logic [1:0]  err_code;

   int          checks = 0;
   int          failures = 0;
   logic [2:0]  exp_q[$];

   ctrl_monitor dut (
      .clk(clk), .reset(reset), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
      .regdst(regdst), .zero(zero), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .alucontrol(alucontrol), .err_clr(err_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
      .mstate(mstate), .instr_done(instr_done), .instr_class(instr_class),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input logic [2:0] sel, input logic [15:0] exp);
      cnt_sel = sel;
      #0.2;
      chk(name, {16'h0, cnt_out}, {16'h0, exp});
   endtask

   // Drive one controller sample; returns at the next falling edge
   task automatic step(input int k, input logic pc = 1'b0, input logic z = 1'b0,
                       input logic clr = 1'b0);
      pcen = 0; memwrite = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
      memtoreg = 0; regdst = 0; zero = 0; alusrcb = 2'b00; pcsrc = 2'b00;
      alucontrol = 3'b000; err_clr = clr;
      case (k)
         K_FETCH:  begin irwrite = 1; pcen = 1; alusrcb = 2'b01; alucontrol = 3'b010; end
         K_DECODE: begin alusrcb = 2'b11; alucontrol = 3'b010; end
         K_ADR:    begin alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; end
         K_REX:    begin alusrca = 1; alucontrol = 3'b010; end
         K_BEX:    begin alusrca = 1; pcsrc = 2'b01; alucontrol = 3'b110; pcen = pc; zero = z; end
         K_JEX:    begin pcen = 1; pcsrc = 2'b10; end
         K_MRD:    begin iord = 1; end
         K_MWR:    begin memwrite = 1; iord = 1; end
         K_MWB:    begin regwrite = 1; memtoreg = 1; end
         K_AWB:    begin regwrite = 1; end
         K_RWB:    begin regwrite = 1; regdst = 1; end
         K_CONF:   begin regwrite = 1; memwrite = 1; end
         default:  begin end
      endcase
      if (k != K_BASE) @(negedge clk);
   endtask

   task automatic do_reset();
      step(K_BASE);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every completion pulse must match the queued class
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (instr_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", {29'h0, instr_class}, 32'hFFFF_FFFF);
            else chk("done_class", {29'h0, instr_class}, {29'h0, exp_q.pop_front()});
         end else begin
            chk("class_idle_zero", {29'h0, instr_class}, 32'h0);
         end
      end
   endtask

   initial begin
      cnt_sel = 3'd0;
      step(K_BASE);
      fork monitor(); join_none
      #1 reset = 1'b0;
      #1;
      chk("rst_mstate", {29'h0, mstate}, 0);
      chk("rst_done", {31'h0, instr_done}, 0);
      chk("rst_err", {31'h0, err}, 0);
      chk("rst_code", {30'h0, err_code}, 0);
      chk_cnt("rst_total", 3'd0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // LW
      step(K_FETCH); step(K_DECODE); step(K_ADR);
      chk("lw_postadr", {29'h0, mstate}, 3);
      step(K_MRD);
      exp_q.push_back(3'd1); step(K_MWB);
      chk_cnt("lw_cnt", 3'd1, 16'd1);
      chk_cnt("lw_total", 3'd0, 16'd1);
      chk("lw_mstate", {29'h0, mstate}, 0);
      do_reset();

      // SW then ADDI back to back
      step(K_FETCH); step(K_DECODE); step(K_ADR);
      exp_q.push_back(3'd2); step(K_MWR);
      step(K_FETCH); step(K_DECODE); step(K_ADR);
      exp_q.push_back(3'd5); step(K_AWB);
      chk_cnt("sw_cnt", 3'd2, 16'd1);
      chk_cnt("addi_cnt", 3'd5, 16'd1);
      chk_cnt("swaddi_total", 3'd0, 16'd2);

      // Partial LW interrupted by asynchronous reset, then J
      step(K_FETCH); step(K_DECODE); step(K_ADR); step(K_MRD);
      chk("lw_memwb", {29'h0, mstate}, 4);
      reset = 1'b0;
      #0.2;
      chk("arst_mstate", {29'h0, mstate}, 0);
      chk("arst_done", {31'h0, instr_done}, 0);
      chk("arst_class", {29'h0, instr_class}, 0);
      chk("arst_err", {31'h0, err}, 0);
      chk("arst_code", {30'h0, err_code}, 0);
      chk_cnt("arst_total", 3'd0, 16'd0);
      chk_cnt("arst_sw", 3'd2, 16'd0);
      @(negedge clk);
      reset = 1'b1;
      step(K_FETCH); step(K_DECODE);
      exp_q.push_back(3'd6); step(K_JEX);
      chk_cnt("j_cnt", 3'd6, 16'd1);
      chk_cnt("j_total", 3'd0, 16'd1);

      // BEQ taken, BEQ not taken, then BEQ with pcen disagreeing with zero
      step(K_FETCH); step(K_DECODE);
      exp_q.push_back(3'd4); step(K_BEX, 1'b1, 1'b1);
      step(K_FETCH); step(K_DECODE);
      exp_q.push_back(3'd4); step(K_BEX, 1'b0, 1'b0);
      chk_cnt("beq_cnt", 3'd4, 16'd2);
      chk_cnt("beq_taken", 3'd7, 16'd1);
      chk_cnt("beq_total", 3'd0, 16'd3);
      chk("beq_noerr", {31'h0, err}, 0);
      step(K_FETCH); step(K_DECODE); step(K_BEX, 1'b1, 1'b0);
      chk("beqbad_err", {31'h0, err}, 1);
      chk("beqbad_code", {30'h0, err_code}, 2'b11);
      chk("beqbad_mstate", {29'h0, mstate}, 0);
      chk_cnt("beqbad_cnt", 3'd4, 16'd2);
      chk_cnt("beqbad_taken", 3'd7, 16'd1);
      do_reset();

      // RTYPE with wrong writeback, recovery, and error-clear behaviour
      step(K_FETCH); step(K_DECODE); step(K_REX);
      chk("rt_rwb", {29'h0, mstate}, 5);
      step(K_MWB);
      chk("rt_err", {31'h0, err}, 1);
      chk("rt_code", {30'h0, err_code}, 2'b01);
      chk("rt_mstate", {29'h0, mstate}, 0);
      chk_cnt("rt_cnt", 3'd3, 16'd0);
      chk_cnt("rt_total", 3'd0, 16'd0);
      step(K_FETCH);
      chk("rec_mstate", {29'h0, mstate}, 1);
      chk("rec_sticky", {31'h0, err}, 1);
      step(K_DECODE, 1'b0, 1'b0, 1'b1);
      chk("clr_err", {31'h0, err}, 0);
      chk("clr_code", {30'h0, err_code}, 0);
      chk("clr_mstate", {29'h0, mstate}, 2);
      step(K_MWB);
      chk("mis_code", {30'h0, err_code}, 2'b01);
      step(K_CONF);
      chk("first_wins", {30'h0, err_code}, 2'b01);
      step(K_CONF, 1'b0, 1'b0, 1'b1);
      chk("clr_new_err", {31'h0, err}, 1);
      chk("clr_new_code", {30'h0, err_code}, 2'b10);
      do_reset();

      // J counter wrap: preload the J counter to its terminal value
      force dut.cnt_j_p1 = 16'hFFFF;
      #0.2;
      release dut.cnt_j_p1;
      step(K_FETCH); step(K_DECODE);
      exp_q.push_back(3'd6); step(K_JEX);
      chk_cnt("wrap_j", 3'd6, 16'h0000);
      chk_cnt("wrap_total", 3'd0, 16'd1);
      chk("wrap_err", {31'h0, err}, 0);

      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_monitor.md
CTRL_MONITOR -- requirements
Module: ctrl_monitor

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-003 SHALL have controller-observation inputs pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zero  in  1 each  sampled controller outputs plus ALU zero flag.
REQ-004 SHALL have inputs alusrcb  in  2, pcsrc  in  2, alucontrol  in  3  sampled controller outputs.
REQ-005 SHALL have port err_clr  in  1  synchronous clear of the error flag and error code.
REQ-006 SHALL have port cnt_sel  in  3  counter select: 0 total, 1 LW, 2 SW, 3 RTYPE, 4 BEQ, 5 ADDI, 6 J, 7 BEQ-taken.
REQ-007 SHALL have output cnt_out  out  16  combinational mux of the counter selected by cnt_sel.
REQ-008 SHALL have outputs mstate  out  3, instr_done  out  1, instr_class  out  3, err  out  1, err_code  out  2.

Function
REQ-009 SHALL sample all observation inputs on every rising clk edge; each sample is one controller cycle.
REQ-010 SHALL classify each sample against these signatures (unlisted fields don't-care; "no-en" = pcen=irwrite=memwrite=regwrite=0):
  - FETCH: irwrite=1, pcen=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00, memwrite=0, regwrite=0, alucontrol=010.
  - DECODE: no-en, alusrca=0, alusrcb=11, alucontrol=010.
  - ADR (MEMADR or ADDIEX): no-en, alusrca=1, alusrcb=10, alucontrol=010.
  - REX: no-en, alusrca=1, alusrcb=00, pcsrc=00.
  - BEX: irwrite=memwrite=regwrite=0, alusrca=1, alusrcb=00, pcsrc=01, alucontrol=110.
  - JEX: pcen=1, irwrite=memwrite=regwrite=0, pcsrc=10.
  - MRD: no-en, iord=1. MWR: memwrite=1, iord=1, pcen=irwrite=regwrite=0.
  - MWB: regwrite=1, regdst=0, memtoreg=1. AWB: regwrite=1, regdst=0, memtoreg=0. RWB: regwrite=1, regdst=1, memtoreg=0.
REQ-011 SHALL track expectation state mstate: 0 EXP_FETCH, 1 EXP_DECODE, 2 EXP_EXEC, 3 EXP_POSTADR, 4 EXP_MEMWB, 5 EXP_RWB; codes 6-7 unused.
REQ-012 SHALL transition: EXP_FETCH+FETCH->EXP_DECODE; EXP_DECODE+DECODE->EXP_EXEC; EXP_EXEC+ADR->EXP_POSTADR, +REX->EXP_RWB, +BEX->EXP_FETCH (BEQ done), +JEX->EXP_FETCH (J done); EXP_POSTADR+MRD->EXP_MEMWB, +MWR->EXP_FETCH (SW done), +AWB->EXP_FETCH (ADDI done); EXP_MEMWB+MWB->EXP_FETCH (LW done); EXP_RWB+RWB->EXP_FETCH (RTYPE done).
REQ-013 SHALL resolve the ADR ambiguity only at the following sample, never earlier.
REQ-014 SHALL, on instruction completion, assert instr_done for exactly one cycle starting the clock after the final sample, with instr_class 1 LW, 2 SW, 3 RTYPE, 4 BEQ, 5 ADDI, 6 J; instr_class SHALL be 0 whenever instr_done=0.
REQ-015 SHALL increment the total counter and the class counter in the same edge that sets instr_done; BEQ-taken counter SHALL increment on a BEX sample with pcen=1.
REQ-016 SHALL let all 16-bit counters wrap 0xFFFF->0x0000 without flagging an error.
REQ-017 SHALL detect errors with priority: code 2'b10 enable conflict (memwrite&regwrite, or irwrite&~pcen); then 2'b11 BEX with pcen!=zero; then 2'b01 sample not matching the expected signature.
REQ-018 SHALL, on any error, set err=1 and latch err_code only if err was 0 (first error wins), count nothing for that sample, and force mstate to EXP_FETCH.
REQ-019 SHALL keep err sticky until err_clr=1 at an edge; if err_clr and a new error coincide, the new error SHALL be latched.

Reset
REQ-020 SHALL, while reset=0, drive mstate=0, instr_done=0, instr_class=0, err=0, err_code=0 and all counters to 0.
REQ-021 SHALL treat the first sample after reset deassertion as EXP_FETCH; reset mid-instruction discards the partial instruction with no count.

Verification
REQ-022 LW: FETCH, DECODE, ADR, MRD, MWB samples -> instr_done=1, instr_class=1 one clock after MWB; cnt_sel=1 gives 1, cnt_sel=0 gives 1.
REQ-023 SW then ADDI: FETCH, DECODE, ADR, MWR then FETCH, DECODE, ADR, AWB -> classes 2 then 5; counters SW=1, ADDI=1, total=2.
REQ-024 BEQ with zero=1, pcen=1 then zero=0, pcen=0 -> two BEQ completions, cnt_sel=4 gives 2, cnt_sel=7 gives 1; BEQ with zero=0, pcen=1 -> err=1, err_code=11.
REQ-025 RTYPE sample RWB replaced by MWB -> err_code=01, mstate=0, RTYPE count 0; next legal FETCH accepted; err_clr clears err.
REQ-026 reset=0 asserted mid-LW at EXP_MEMWB -> all outputs 0 asynchronously; after release, full J sequence FETCH, DECODE, JEX -> class 6, total=1.
REQ-027 0xFFFF J instructions preloaded via repeated sequence, one more J -> cnt_sel=6 reads 0x0000, err=0.
